// File: rtl/ifetch_prefetcher.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_prefetcher
//  Brief    : Single-outstanding instruction prefetcher with a small FIFO
//             buffer, redirect flush and stale-response drain.
//  Revision : 1.0
// ============================================================================
module ifetch_prefetcher #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [31:0]        r_fetch_pc;
   logic [31:0]        r_pending_pc;
   logic [CNT_W-1:0]   r_count;
   logic [PTR_W-1:0]   r_head;
   logic [PTR_W-1:0]   r_tail;
   logic [31:0]        r_buf_data [DEPTH];
   logic [31:0]        r_buf_pc   [DEPTH];

   logic               w_req_fire;
   logic               w_push;
   logic               w_pop;
   logic               w_nonempty;
   logic               w_unused;

   // Low redirect bits are dropped: fetch addresses are always word aligned.
   assign w_unused = &{1'b0, redirect_pc[1:0]};

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == c_last_ptr) ? '0 : p + 1'b1;
   endfunction

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and handshake decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_nonempty    = (r_count != '0);
      // Request is withheld while reset is held so nothing escapes mid-reset.
      mem_req_valid = (r_state == IDLE) && (r_count < c_depth) &&
                      !redirect_valid && !rst;
      mem_req_addr  = r_fetch_pc;
      w_req_fire    = mem_req_valid && mem_req_ready;
      w_push        = (r_state == WAIT) && mem_resp_valid && !redirect_valid;
      w_pop         = w_nonempty && inst_ready && !redirect_valid;

      case (r_state)
         IDLE: begin
            if (w_req_fire) begin
               w_state_next = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               w_state_next = mem_resp_valid ? IDLE : DRAIN;
            end else if (mem_resp_valid) begin
               w_state_next = IDLE;
            end
         end
         DRAIN: begin
            if (!redirect_valid && mem_resp_valid) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Fetch address, pending address and buffer bookkeeping
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc   <= RESET_PC;
         r_pending_pc <= '0;
         r_count      <= '0;
         r_head       <= '0;
         r_tail       <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= {redirect_pc[31:2], 2'b00};
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
      end else begin
         if (w_req_fire) begin
            r_pending_pc <= r_fetch_pc;
            r_fetch_pc   <= r_fetch_pc + 32'd4;
         end
         if (w_push) begin
            r_tail <= ptr_inc(r_tail);
         end
         if (w_pop) begin
            r_head <= ptr_inc(r_head);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset; validity is carried by r_count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_buf_data[r_tail] <= mem_resp_data;
         r_buf_pc[r_tail]   <= r_pending_pc;
      end
   end

   assign inst_valid = w_nonempty;
   assign inst_data  = w_nonempty ? r_buf_data[r_head] : '0;
   assign inst_pc    = w_nonempty ? r_buf_pc[r_head]   : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_prefetcher
//  Brief    : Directed self-checking bench for ifetch_prefetcher.
//  Revision : 1.0
// ============================================================================
module tb_ifetch_prefetcher;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   int          n_checks;
   int          n_fail;

   // Memory responder state
   bit          pend;
   int          cnt;
   int          lat;
   int          n_acc;
   logic [31:0] pend_addr;

   ifetch_prefetcher #(
      .RESET_PC (32'h8000_0000),
      .DEPTH    (2)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: sample the handshake, step the responder, settle.
   task automatic tick();
      logic        acc;
      logic        rv;
      logic [31:0] a;
      #1;
      acc = mem_req_valid && mem_req_ready;
      a   = mem_req_addr;
      rv  = mem_resp_valid;
      @(posedge clk);
      #1;
      if (rv) mem_resp_valid = 1'b0;
      if (acc) begin
         n_acc++;
         pend      = 1'b1;
         pend_addr = a;
         cnt       = lat;
      end
      if (pend) begin
         if (cnt <= 1) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(pend_addr);
            pend           = 1'b0;
         end else begin
            cnt--;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      pend           = 1'b0;
      mem_resp_valid = 1'b0;
      tick();
      tick();
      rst   = 1'b0;
      n_acc = 0;
      #1;
   endtask

   task automatic expect_inst(input string tag, input logic [31:0] pc, input logic [31:0] data);
      int n;
      n = 0;
      while (!inst_valid && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
      check({tag, "_pc"},    inst_pc,   pc);
      check({tag, "_data"},  inst_data, data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      lat            = 1;
      n_acc          = 0;
      pend           = 1'b0;
      cnt            = 0;
      pend_addr      = '0;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_req_ready  = 1'b1;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      inst_ready     = 1'b1;

      // Reset state while rst is held
      tick();
      tick();
      check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);

      // Streaming from reset, latency 1, core always ready
      do_reset();
      check("s1_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("s1_req_addr", mem_req_addr, 32'h8000_0000);
      tick();
      check("s1_wait_no_req", {31'd0, mem_req_valid}, 32'd0);
      check("s1_no_comb_path", {31'd0, inst_valid}, 32'd0);
      tick();
      check("s1_i0_valid", {31'd0, inst_valid}, 32'd1);
      check("s1_i0_pc", inst_pc, 32'h8000_0000);
      check("s1_i0_data", inst_data, 32'h5EAD_BEEF);
      check("s1_req_addr1", mem_req_addr, 32'h8000_0004);
      tick();
      tick();
      check("s1_i1_pc", inst_pc, 32'h8000_0004);
      check("s1_i1_data", inst_data, 32'h5EAD_BEEB);
      tick();
      tick();
      check("s1_i2_pc", inst_pc, 32'h8000_0008);
      check("s1_i2_data", inst_data, 32'h5EAD_BEE7);

      // Backpressure: exactly DEPTH requests then stall
      inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 12; i++) tick();
      check("bp_req_count", n_acc, 32'd2);
      check("bp_req_stalled", {31'd0, mem_req_valid}, 32'd0);
      check("bp_head_pc", inst_pc, 32'h8000_0000);
      inst_ready = 1'b1;
      tick();
      check("bp_pop_pc", inst_pc, 32'h8000_0004);
      check("bp_pop_data", inst_data, 32'h5EAD_BEEB);
      check("bp_resume_valid", {31'd0, mem_req_valid}, 32'd1);
      check("bp_resume_addr", mem_req_addr, 32'h8000_0008);

      // Redirect while WAIT, response 3 cycles after request
      lat = 3;
      do_reset();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("rd_drain_no_req", {31'd0, mem_req_valid}, 32'd0);
      check("rd_drain_inst", {31'd0, inst_valid}, 32'd0);
      tick();
      check("rd_resp_no_req", {31'd0, mem_req_valid}, 32'd0);
      tick();
      check("rd_dropped", {31'd0, inst_valid}, 32'd0);
      check("rd_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("rd_req_addr", mem_req_addr, 32'h8000_0100);
      expect_inst("rd_new", 32'h8000_0100, 32'h5EAD_BFEF);

      // Redirect with full buffer, spurious response and pop; target wraps
      lat        = 1;
      inst_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 8; i++) tick();
      check("fl_full_valid", {31'd0, inst_valid}, 32'd1);
      check("fl_full_no_req", {31'd0, mem_req_valid}, 32'd0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      inst_ready     = 1'b1;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h0BAD_0BAD;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("fl_flushed", {31'd0, inst_valid}, 32'd0);
      check("fl_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("fl_req_addr", mem_req_addr, 32'hFFFF_FFFC);
      tick();
      tick();
      check("wrap_hi_pc", inst_pc, 32'hFFFF_FFFC);
      check("wrap_hi_data", inst_data, 32'h2152_4113);
      check("wrap_next_addr", mem_req_addr, 32'h0000_0000);
      tick();
      expect_inst("wrap_lo", 32'h0000_0000, 32'hDEAD_BEEF);

      // Redirect coincident with response in WAIT: response dropped
      inst_ready = 1'b0;
      do_reset();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1234_567B;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("rw_dropped", {31'd0, inst_valid}, 32'd0);
      check("rw_req_valid", {31'd0, mem_req_valid}, 32'd1);
      check("rw_req_addr", mem_req_addr, 32'h1234_5678);
      expect_inst("rw_new", 32'h1234_5678, 32'hCC99_E897);

      // Asynchronous reset mid-WAIT with buffered data
      do_reset();
      tick();
      tick();
      tick();
      check("mr_pre_valid", {31'd0, inst_valid}, 32'd1);
      rst            = 1'b1;
      pend           = 1'b0;
      mem_resp_valid = 1'b0;
      #1;
      check("mr_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check("mr_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("mr_inst_data", inst_data, 32'd0);
      check("mr_inst_pc", inst_pc, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("mr_req_addr", mem_req_addr, 32'h8000_0000);
      expect_inst("mr_first", 32'h8000_0000, 32'h5EAD_BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ifetch_prefetcher.md
IFETCH_PREFETCHER -- requirements
Module: ifetch_prefetcher

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL provide parameter DEPTH, default 2, instruction buffer entries (legal 2..8).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port redirect_valid  input  1  pipeline redirect (branch/jump taken).
REQ-006 SHALL have port redirect_pc  input  32  new fetch address.
REQ-007 SHALL have port mem_req_valid  output  1  instruction memory read request.
REQ-008 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port mem_req_addr  output  32  word-aligned fetch address.
REQ-010 SHALL have port mem_resp_valid  input  1  read data returned.
REQ-011 SHALL have port mem_resp_data  input  32  returned instruction word.
REQ-012 SHALL have port inst_valid  output  1  buffer head holds an instruction.
REQ-013 SHALL have port inst_ready  input  1  core consumes head.
REQ-014 SHALL have port inst_data  output  32  head instruction.
REQ-015 SHALL have port inst_pc  output  32  address of head instruction.

Function
REQ-016 SHALL implement FSM states IDLE (may issue), WAIT (one request outstanding), DRAIN (outstanding response to be discarded).
REQ-017 SHALL allow at most one outstanding memory request.
REQ-018 SHALL drive mem_req_valid = (state==IDLE) & (count<DEPTH) & !redirect_valid; mem_req_addr = fetch_pc.
REQ-019 SHALL, on mem_req_valid & mem_req_ready: record fetch_pc as pending_pc, fetch_pc <= fetch_pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), IDLE->WAIT.
REQ-020 SHALL hold mem_req_addr stable while mem_req_valid=1 and not accepted.
REQ-021 SHALL ignore mem_resp_valid in IDLE; response never accepted in the same cycle as its request (min latency 1).
REQ-022 SHALL, in WAIT with mem_resp_valid and no redirect, push {mem_resp_data, pending_pc} at buffer tail, WAIT->IDLE.
REQ-023 SHALL drive inst_valid = (count!=0); inst_data/inst_pc from head entry; pop on inst_valid & inst_ready.
REQ-024 SHALL keep count unchanged on simultaneous push and pop; push into full buffer impossible by REQ-018 credit rule.
REQ-025 SHALL buffer entries in FIFO order, head/tail pointers wrapping modulo DEPTH.
REQ-026 SHALL give redirect_valid top priority: next cycle count=0, fetch_pc = {redirect_pc[31:2],2'b00}, any same-cycle push/pop/request suppressed.
REQ-027 SHALL on redirect: IDLE->IDLE; WAIT without mem_resp_valid ->DRAIN; WAIT with mem_resp_valid -> IDLE, response dropped; DRAIN->DRAIN.
REQ-028 SHALL in DRAIN discard the next mem_resp_valid (no push) and go DRAIN->IDLE.
REQ-029 SHALL produce no combinational path from mem_resp_* to inst_* (instruction visible one cycle after response).

Reset
REQ-030 SHALL on rst=1 asynchronously set state=IDLE, fetch_pc=RESET_PC, pending_pc=0, count=0, head=tail=0; outputs mem_req_valid=0 while rst held, inst_valid=0, inst_data=0, inst_pc=0.
REQ-031 SHALL drop any in-flight response arriving after reset deasserts in IDLE (REQ-021); mid-operation reset loses all buffered instructions.
REQ-032 SHALL issue first request, addr=RESET_PC, in the first cycle after rst falls if mem_req_ready is sampled.

Verification
REQ-033 Reset release, mem_req_ready=1, resp latency 1, inst_ready=1 -> inst_pc sequence 8000_0000, 8000_0004, 8000_0008 with matching data.
REQ-034 inst_ready=0, memory always ready -> exactly DEPTH=2 requests, mem_req_valid then 0; raise inst_ready -> entries pop in order, fetching resumes.
REQ-035 redirect_pc=8000_0102 while WAIT, response returns 3 cycles later -> response dropped, next request addr 8000_0100, inst_valid=0 until its data returns.
REQ-036 redirect same cycle as mem_resp_valid and pop with 2 buffered entries -> next cycle count=0, state IDLE, request to redirect target.
REQ-037 redirect_pc=FFFF_FFFC -> fetch addrs FFFF_FFFC then 0000_0000.
REQ-038 rst asserted mid-WAIT with buffer full -> outputs cleared immediately, post-reset first inst_pc=RESET_PC.
